// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a runtime-loadable pattern, length and
// overlap mode, and a registered Moore match flag. SEQDET_MATCH_COUNT_EN adds a saturating match counter.
module seq_detect_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               cnt_clr
);

    localparam logic [LEN_W-1:0]   LenMax = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LenOne = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LenRst = LEN_W'(3);
    localparam logic [MAX_LEN-1:0] PatRst = MAX_LEN'(3'b101);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               match_q;

    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] nh;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic               fill_full;
    logic               hit;
    logic [LEN_W-1:0]   fill_d;

    // Oldest history bit shifts out unused; it only exists to keep hist_q MAX_LEN wide.
    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[MAX_LEN-1];

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LenOne;
        end else if (cfg_len > LenMax) begin
            len_clamped = LenMax;
        end
    end

    assign nh = {hist_q[MAX_LEN-2:0], din};

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    // One extra bit so fill_q + 1 cannot wrap when len_q == 2^LEN_W - 1.
    assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    assign fill_full = (fill_inc >= {1'b0, len_q});
    assign hit       = fill_full && ((nh & len_mask) == (pat_q & len_mask));

    always_comb begin
        fill_d = fill_inc[LEN_W-1:0];
        if (hit && !ovl_q) begin
            fill_d = '0;
        end else if (fill_full) begin
            fill_d = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PatRst;
            len_q   <= LenRst;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (cfg_load) begin
            pat_q   <= cfg_pattern;
            len_q   <= len_clamped;
            ovl_q   <= cfg_overlap;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (din_valid) begin
            hist_q  <= nh;
            fill_q  <= fill_d;
            match_q <= hit;
        end
    end

    assign dout = match_q;

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (din_valid && !cfg_load && hit && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
